// File: rtl/multiword_add_pkg.sv
// Shared types and width helpers for the multi-word chunked adder sequencer.
package multiword_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int op_w_f(input int chunk_w, input int num_chunks);
    return chunk_w * num_chunks;
  endfunction

  function automatic int idx_w_f(input int num_chunks);
    return (num_chunks > 1) ? $clog2(num_chunks) : 1;
  endfunction

endpackage

// File: rtl/fulladder.sv
// Narrow ripple adder used as the per-chunk datapath; width is the MSB index.
module fulladder #(
  parameter int width = 3
) (
  input  logic [width:0] a,
  input  logic [width:0] b,
  input  logic           ci,
  output logic [width:0] s,
  output logic           co
);

  logic [width+1:0] tot;

  assign tot = {1'b0, a} + {1'b0, b} + {{(width + 1){1'b0}}, ci};
  assign s   = tot[width:0];
  assign co  = tot[width+1];

endmodule

// File: rtl/multiword_add_ctrl.sv
// Adds two wide operands one chunk per cycle through a single narrow adder.
// Optional MULTIWORD_ADD_SUB_EN adds a 'sub' input for A - B.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one chunk added per cycle, LSB chunk first
// DONE  | result held until out_ready
module multiword_add_ctrl
  import multiword_add_pkg::*;
#(
  parameter int  CHUNK_W    = 4,
  parameter int  NUM_CHUNKS = 4,
  localparam int OP_W       = op_w_f(CHUNK_W, NUM_CHUNKS),
  localparam int IDX_W      = idx_w_f(NUM_CHUNKS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] op_a,
  input  logic [OP_W-1:0] op_b,
  input  logic            c_in,
`ifdef MULTIWORD_ADD_SUB_EN
  input  logic            sub,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] sum,
  output logic            c_out,
  output logic            busy
);

  state_t            state_q, state_d;
  logic [OP_W-1:0]   a_sh_q, a_sh_d;
  logic [OP_W-1:0]   b_sh_q, b_sh_d;
  logic [OP_W-1:0]   sum_q, sum_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              carry_q, carry_d;
  logic              c_out_q, c_out_d;
  logic [CHUNK_W-1:0] chunk_b;
  logic [CHUNK_W-1:0] chunk_s;
  logic              chunk_co;
  logic              init_carry;

`ifdef MULTIWORD_ADD_SUB_EN
  logic sub_q, sub_d;

  // Subtraction is two's complement: invert B chunks and seed the carry with 1.
  assign chunk_b    = b_sh_q[CHUNK_W-1:0] ^ {CHUNK_W{sub_q}};
  assign init_carry = sub ? 1'b1 : c_in;
`else
  assign chunk_b    = b_sh_q[CHUNK_W-1:0];
  assign init_carry = c_in;
`endif

  fulladder #(
    .width(CHUNK_W - 1)
  ) u_chunk_add (
    .a (a_sh_q[CHUNK_W-1:0]),
    .b (chunk_b),
    .ci(carry_q),
    .s (chunk_s),
    .co(chunk_co)
  );

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign c_out     = c_out_q;

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
`ifdef MULTIWORD_ADD_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = op_a;
          b_sh_d  = op_b;
          carry_d = init_carry;
          idx_d   = '0;
`ifdef MULTIWORD_ADD_SUB_EN
          sub_d   = sub;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[int'(idx_q) * CHUNK_W +: CHUNK_W] = chunk_s;
        carry_d = chunk_co;
        a_sh_d  = a_sh_q >> CHUNK_W;
        b_sh_d  = b_sh_q >> CHUNK_W;
        if (idx_q == IDX_W'(NUM_CHUNKS - 1)) begin
          c_out_d = chunk_co;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
`ifdef MULTIWORD_ADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
`ifdef MULTIWORD_ADD_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

endmodule
